// File: rtl/pe_operand_loader.sv
// Operand fetch unit: streams one tile of words from BRAM into a register bank,
// hands the bank to the PE array, and repeats for each tile.
module pe_operand_loader #(
    parameter int DATA_W     = 32,
    parameter int ADDR_W     = 32,
    parameter int NUM_PE     = 4,
    parameter int OPS_PER_PE = 2,
    parameter int RD_LAT     = 1,
    parameter int ADDR_STEP  = 4
) (
    input  logic                                 i_clk,
    input  logic                                 i_rst,
    input  logic                                 i_start,
    input  logic [ADDR_W-1:0]                    i_base_addr,
    input  logic [15:0]                          i_num_tiles,
    output logic                                 o_bram_en,
    output logic [ADDR_W-1:0]                    o_bram_addr,
    input  logic [DATA_W-1:0]                    i_bram_rdata,
    output logic [NUM_PE*OPS_PER_PE*DATA_W-1:0]  o_pe_operands,
    output logic                                 o_pe_en,
    input  logic                                 i_pe_done,
    output logic [15:0]                          o_tile_idx,
    output logic                                 o_busy,
    output logic                                 o_done
);
    localparam int WORDS = NUM_PE * OPS_PER_PE;
    localparam int CNT_W = $clog2(WORDS + 1);
    localparam logic [ADDR_W-1:0] STEP        = ADDR_W'(ADDR_STEP);
    localparam logic [ADDR_W-1:0] TILE_STRIDE = ADDR_W'(WORDS * ADDR_STEP);

    typedef enum logic [2:0] {S_IDLE, S_READ, S_FIRE, S_WAIT, S_FINISH} state_t;

    state_t             r_state;
    logic [ADDR_W-1:0]  r_cur_base;
    logic [15:0]        r_limit;
    logic [15:0]        r_tile_idx;
    logic [CNT_W-1:0]   r_iss_cnt;
    logic [CNT_W-1:0]   r_cap_cnt;
    logic               r_bram_en;
    logic [ADDR_W-1:0]  r_bram_addr;
    logic               r_pe_en;
    logic               r_busy;
    logic               r_done;
    // bit k is high k cycles after a read was issued; the top bit marks valid rdata
    logic [RD_LAT:1]    r_vld_pipe;
    logic [DATA_W-1:0]  r_bank [WORDS];

    logic               w_cap;
    logic               w_last_cap;
    logic               w_last_tile;
    logic [ADDR_W-1:0]  w_next_base;

    assign w_cap       = r_vld_pipe[RD_LAT];
    assign w_last_cap  = w_cap && (r_cap_cnt == CNT_W'(WORDS - 1));
    assign w_last_tile = (r_tile_idx == r_limit - 16'd1);
    assign w_next_base = r_cur_base + TILE_STRIDE;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_cur_base  <= '0;
            r_limit     <= '0;
            r_tile_idx  <= '0;
            r_iss_cnt   <= '0;
            r_cap_cnt   <= '0;
            r_bram_en   <= 1'b0;
            r_bram_addr <= '0;
            r_pe_en     <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_vld_pipe  <= '0;
        end else begin
            r_done     <= 1'b0;
            r_vld_pipe <= (r_vld_pipe << 1) | (RD_LAT)'(r_bram_en);
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_cur_base <= i_base_addr;
                        r_limit    <= i_num_tiles;
                        r_tile_idx <= '0;
                        r_cap_cnt  <= '0;
                        r_busy     <= 1'b1;
                        if (i_num_tiles == 16'd0) begin
                            r_state <= S_FINISH;
                        end else begin
                            r_state     <= S_READ;
                            r_bram_en   <= 1'b1;
                            r_bram_addr <= i_base_addr;
                            r_iss_cnt   <= CNT_W'(1);
                        end
                    end
                end
                S_READ: begin
                    if (r_bram_en) begin
                        if (r_iss_cnt == CNT_W'(WORDS)) begin
                            r_bram_en <= 1'b0;
                        end else begin
                            r_bram_addr <= r_bram_addr + STEP;
                            r_iss_cnt   <= r_iss_cnt + CNT_W'(1);
                        end
                    end
                    if (w_cap) r_cap_cnt <= r_cap_cnt + CNT_W'(1);
                    if (w_last_cap) r_state <= S_FIRE;
                end
                S_FIRE: begin
                    r_pe_en <= 1'b1;
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (i_pe_done) begin
                        r_pe_en <= 1'b0;
                        if (w_last_tile) begin
                            r_state <= S_FINISH;
                        end else begin
                            r_tile_idx  <= r_tile_idx + 16'd1;
                            r_cur_base  <= w_next_base;
                            r_bram_addr <= w_next_base;
                            r_bram_en   <= 1'b1;
                            r_iss_cnt   <= CNT_W'(1);
                            r_cap_cnt   <= '0;
                            r_state     <= S_READ;
                        end
                    end
                end
                S_FINISH: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // One register per operand word; untouched words keep the previous tile's value.
    for (genvar k = 0; k < WORDS; k++) begin : g_word
        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                r_bank[k] <= '0;
            end else if (w_cap && (r_cap_cnt == CNT_W'(k))) begin
                r_bank[k] <= i_bram_rdata;
            end
        end
        assign o_pe_operands[k*DATA_W +: DATA_W] = r_bank[k];
    end

    assign o_bram_en   = r_bram_en;
    assign o_bram_addr = r_bram_addr;
    assign o_pe_en     = r_pe_en;
    assign o_tile_idx  = r_tile_idx;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
endmodule
